pwm_duty_meter: RTL and testbench

Receive-side companion of the PWM generator: measures an incoming PWM waveform and recovers its duty cycle as a 0..100 percent code on the same 7-bit scale as the generator's dc input. Synchronises pwm_in, counts high time and period between consecutive rising edges, then runs a sequential 7-step divider. Used for loopback self-test of the PWM output pins and for decoding external PWM sensors.

---
 rtl/pwm_duty_meter.sv | 168 ++++++++++++++++
 tb/tb_pwm_duty_meter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_meter.sv
// Measures an asynchronous PWM waveform and reports its duty cycle as 0..100 percent.
// Define PWM_DUTY_METER_OVERRUN_EN to add the sticky overrun output.
module pwm_duty_meter #(
    parameter int CNT_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_in,
    output logic [6:0] dc,
    output logic       dc_valid,
    output logic       busy,
`ifdef PWM_DUTY_METER_OVERRUN_EN
    output logic       overrun,
`endif
    output logic [1:0] dbg_state
);

    // dc_valid is a one-cycle strobe qualifying dc; there is no ready, the consumer must take it.
    localparam int NW = CNT_W + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [NW-1:0]    HUNDRED = NW'(100);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIV     = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic [CNT_W-1:0]       per_q, per_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic [CNT_W-1:0]       div_p_q, div_p_d;
    logic [NW-1:0]          rem_q, rem_d;
    logic [6:0]             quot_q, quot_d;
    logic [2:0]             bit_q, bit_d;
    logic [6:0]             dc_q, dc_d;
    logic                   dc_valid_q, dc_valid_d;
    logic                   to_done_q, to_done_d;
    logic [NW-1:0]          shifted;
`ifdef PWM_DUTY_METER_OVERRUN_EN
    logic                   ovr_q, ovr_d;
`endif

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pwm_in};
        prev_d     = sync_q[SYNC_STAGES-1];
        rise_d     = sync_q[SYNC_STAGES-1] & ~prev_q;
        state_d    = state_q;
        per_d      = per_q;
        high_d     = high_q;
        div_p_d    = div_p_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        bit_d      = bit_q;
        dc_d       = dc_q;
        dc_valid_d = 1'b0;
        to_done_d  = to_done_q;
        shifted    = '0;
`ifdef PWM_DUTY_METER_OVERRUN_EN
        ovr_d      = ovr_q;
`endif

        // prev_q is the level aligned with rise_q; the rise cycle is the first of the new period.
        if (rise_q) begin
            per_d     = CNT_W'(1);
            high_d    = {{(CNT_W-1){1'b0}}, prev_q};
            to_done_d = 1'b0;
        end else begin
            if (per_q != CNT_MAX)
                per_d = per_q + CNT_W'(1);
            if (prev_q && (high_q != CNT_MAX))
                high_d = high_q + CNT_W'(1);
        end

        case (state_q)
            IDLE, MEASURE: begin
                if (rise_q) begin
                    if (state_q == IDLE) begin
                        state_d = MEASURE;
                    end else begin
                        div_p_d = per_q;
                        rem_d   = NW'(high_q) * HUNDRED;
                        quot_d  = '0;
                        bit_d   = 3'd6;
                        state_d = DIV;
                    end
                end else if ((per_q == CNT_MAX) && !to_done_q) begin
                    // No edge for a full counter range: the waveform is stuck at 0 % or 100 %.
                    dc_d       = prev_q ? 7'd100 : 7'd0;
                    dc_valid_d = 1'b1;
                    to_done_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            DIV: begin
`ifdef PWM_DUTY_METER_OVERRUN_EN
                if (rise_q)
                    ovr_d = 1'b1;
`endif
                shifted = {7'b0, div_p_q} << bit_q;
                if (rem_q >= shifted) begin
                    rem_d  = rem_q - shifted;
                    quot_d = quot_q | (7'd1 << bit_q);
                end
                if (bit_q == 3'd0) begin
                    dc_d       = (quot_d > 7'd100) ? 7'd100 : quot_d;
                    dc_valid_d = 1'b1;
                    state_d    = MEASURE;
                end else begin
                    bit_d = bit_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            rise_q     <= 1'b0;
            per_q      <= '0;
            high_q     <= '0;
            div_p_q    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            bit_q      <= '0;
            dc_q       <= '0;
            dc_valid_q <= 1'b0;
            to_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            rise_q     <= rise_d;
            per_q      <= per_d;
            high_q     <= high_d;
            div_p_q    <= div_p_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            bit_q      <= bit_d;
            dc_q       <= dc_d;
            dc_valid_q <= dc_valid_d;
            to_done_q  <= to_done_d;
        end
    end

`ifdef PWM_DUTY_METER_OVERRUN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovr_q <= 1'b0;
        else
            ovr_q <= ovr_d;
    end
    assign overrun = ovr_q;
`endif

    assign dc        = dc_q;
    assign dc_valid  = dc_valid_q;
    assign busy      = (state_q == DIV) | (rise_q & (state_q == MEASURE));
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter: PWM periods with hand-computed duty codes,
// timeouts, overrun and reset-abort; dc_valid results are checked against exp_q.
module tb_pwm_duty_meter;

    logic       clk = 1'b0;
    logic       reset;
    logic       pwm_in;
    logic [6:0] dc;
    logic       dc_valid;
    logic       busy;
    logic [1:0] dbg_state;
`ifdef PWM_DUTY_METER_OVERRUN_EN
    logic       overrun;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    pwm_duty_meter #(.CNT_W(10), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .pwm_in    (pwm_in),
        .dc        (dc),
        .dc_valid  (dc_valid),
        .busy      (busy),
`ifdef PWM_DUTY_METER_OVERRUN_EN
        .overrun   (overrun),
`endif
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every dc_valid must match the oldest expected duty code.
    always @(negedge clk) begin
        if (!reset && dc_valid) begin
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("dc", 32'(dc), 32'(exp_q.pop_front()));
        end
    end

    // One PWM period; exp_dc (or -1) is the code the rising edge must report for the previous period.
    task automatic pwm_period(input int hi, input int lo, input int exp_dc);
        bit seen;
        seen = 1'b0;
        if (exp_dc >= 0)
            exp_q.push_back(7'(exp_dc));
        pwm_in = 1'b1;
        for (int i = 0; i < hi; i++) begin
            @(negedge clk);
            if (exp_dc >= 0 && hi >= 16) begin
                if (i == 1)
                    check("busy_pre", 32'(busy), 32'd0);
                if (i == 2 || i == 9)
                    check("busy_div", 32'(busy), 32'd1);
                if (i == 10)
                    check("busy_done", 32'(busy), 32'd0);
                if (dc_valid && !seen) begin
                    seen = 1'b1;
                    check("latency", 32'(i + 1), 32'd11);
                end
            end
        end
        if (exp_dc >= 0 && hi >= 16)
            check("valid_seen", 32'(seen), 32'd1);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dc", 32'(dc), 32'd0);
        check("rst_valid", 32'(dc_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
`ifdef PWM_DUTY_METER_OVERRUN_EN
        check("rst_overrun", 32'(overrun), 32'd0);
`endif
        reset = 1'b0;

        // Held low from reset: one dc=0 report, then silence.
        exp_q.push_back(7'd0);
        repeat (2200) @(negedge clk);
        check("drain_low", 32'(exp_q.size()), 32'd0);
        check("state_after_low", 32'(dbg_state), 32'd0);

        // Held high: one dc=100 report, then silence.
        pwm_in = 1'b1;
        exp_q.push_back(7'd100);
        repeat (2200) @(negedge clk);
        check("drain_high", 32'(exp_q.size()), 32'd0);
        check("dc_hold_100", 32'(dc), 32'd100);
        check("state_after_high", 32'(dbg_state), 32'd0);

        pwm_in = 1'b0;
        repeat (30) @(negedge clk);

        // Duty stream: 50, 25, 1, 99 (floors to 98), 50, then 75.
        pwm_period(128, 128, -1);
        pwm_period(128, 128, 50);
        pwm_period(128, 128, 50);
        pwm_period(64, 192, 50);
        pwm_period(64, 192, 25);
        pwm_period(3, 253, 25);
        pwm_period(3, 253, 1);
        pwm_period(253, 3, 1);
        pwm_period(253, 3, 98);
        pwm_period(128, 128, 98);
        pwm_period(192, 64, 50);
        pwm_period(192, 64, 75);
        pwm_period(192, 64, 75);
        check("drain_stream", 32'(exp_q.size()), 32'd0);

        // This edge would report 75; reset lands mid-divide and must suppress it.
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_dc", 32'(dc), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(dc_valid), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        pwm_period(128, 128, -1);
        pwm_period(128, 128, 50);
`ifdef PWM_DUTY_METER_OVERRUN_EN
        check("overrun_clear", 32'(overrun), 32'd0);
`endif

        // Period 6 / high 3: every other edge lands in the divide and is discarded.
        for (int k = 0; k < 10; k++)
            pwm_period(3, 3, (k % 2 == 0) ? 50 : -1);
`ifdef PWM_DUTY_METER_OVERRUN_EN
        check("overrun_set", 32'(overrun), 32'd1);
`endif
        exp_q.push_back(7'd0);
        repeat (1200) @(negedge clk);
        check("drain_overrun", 32'(exp_q.size()), 32'd0);
        check("dc_hold_0", 32'(dc), 32'd0);

        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
